// File: rtl/toggle_monitor.sv
// Toggle-stream monitor: measures edge-to-edge intervals, locks onto EXP_HALF, flags mismatch/stall.
// Optional statistics counters (edge_count, err_count) are built only with TOGGLE_MONITOR_STATS_EN.
module toggle_monitor #(
   parameter int unsigned EXP_HALF = 3,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        toggle_in,
   input  logic        clear,
   output logic        edge_pulse,
   output logic [7:0]  interval,
   output logic        interval_vld,
   output logic        locked,
   output logic        mismatch,
   output logic        stall,
   output logic [15:0] edge_count,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   localparam logic [7:0] EXP_W  = 8'(EXP_HALF);
   localparam logic [7:0] LOCK_W = 8'(LOCK_CNT);
   localparam logic [7:0] TMO_M1 = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] match_q, match_d;
   logic [7:0] cyc_cnt;
   logic       toggle_q;
   logic       edge_det;
   logic       tmo;
   logic [7:0] meas;
   logic       meas_vld;
   logic       mis_evt;
   logic       tmo_evt;

   assign edge_det = toggle_in ^ toggle_q;
   assign meas     = (cyc_cnt == 8'hFF) ? 8'hFF : cyc_cnt + 8'd1;
   // The counter is one short of TIMEOUT here; an edge in this same cycle wins.
   assign tmo      = !edge_det && (cyc_cnt == TMO_M1);

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      meas_vld = 1'b0;
      mis_evt  = 1'b0;
      tmo_evt  = 1'b0;
      case (state_q)
         IDLE: begin
            if (edge_det) begin
               state_d = ACQUIRE;
               match_d = '0;
            end
         end
         ACQUIRE: begin
            if (edge_det) begin
               meas_vld = 1'b1;
               if (meas == EXP_W) begin
                  if (match_q + 8'd1 == LOCK_W) begin
                     state_d = LOCKED;
                     match_d = '0;
                  end else begin
                     match_d = match_q + 8'd1;
                  end
               end else begin
                  match_d = '0;
               end
            end else if (tmo) begin
               state_d = IDLE;
               match_d = '0;
               tmo_evt = 1'b1;
            end
         end
         LOCKED: begin
            if (edge_det) begin
               meas_vld = 1'b1;
               if (meas != EXP_W) begin
                  mis_evt = 1'b1;
                  state_d = ACQUIRE;
                  match_d = '0;
               end
            end else if (tmo) begin
               state_d = IDLE;
               match_d = '0;
               tmo_evt = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            match_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         match_q      <= '0;
         toggle_q     <= 1'b0;
         cyc_cnt      <= '0;
         edge_pulse   <= 1'b0;
         interval     <= '0;
         interval_vld <= 1'b0;
         locked       <= 1'b0;
         mismatch     <= 1'b0;
         stall        <= 1'b0;
      end else begin
         state_q      <= state_d;
         match_q      <= match_d;
         toggle_q     <= toggle_in;
         cyc_cnt      <= edge_det ? 8'd0 : ((cyc_cnt == 8'hFF) ? cyc_cnt : cyc_cnt + 8'd1);
         edge_pulse   <= edge_det;
         interval_vld <= meas_vld;
         locked       <= (state_d == LOCKED);
         if (meas_vld) interval <= meas;
         // clear overrides any flag event in the same cycle
         if (clear) begin
            mismatch <= 1'b0;
            stall    <= 1'b0;
         end else begin
            if (mis_evt) mismatch <= 1'b1;
            if (tmo_evt) stall    <= 1'b1;
         end
      end
   end

`ifdef TOGGLE_MONITOR_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_count <= '0;
         err_count  <= '0;
      end else if (clear) begin
         edge_count <= '0;
         err_count  <= '0;
      end else begin
         if (edge_det) edge_count <= edge_count + 16'd1;
         if (mis_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end
`else
   assign edge_count = '0;
   assign err_count  = '0;
`endif

endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboard bench for toggle_monitor: an edge-level model pushes the expected response for each
// driven toggle edge; a monitor pops and compares on every edge_pulse.
module tb_toggle_monitor;

   localparam int EXP_HALF = 3;
   localparam int LOCK_CNT = 4;
   localparam int TIMEOUT  = 16;
`ifdef TOGGLE_MONITOR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        toggle_in = 1'b0;
   logic        clear     = 1'b0;
   logic        edge_pulse;
   logic [7:0]  interval;
   logic        interval_vld;
   logic        locked;
   logic        mismatch;
   logic        stall;
   logic [15:0] edge_count;
   logic [7:0]  err_count;

   toggle_monitor #(.EXP_HALF(EXP_HALF), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .toggle_in    (toggle_in),
      .clear        (clear),
      .edge_pulse   (edge_pulse),
      .interval     (interval),
      .interval_vld (interval_vld),
      .locked       (locked),
      .mismatch     (mismatch),
      .stall        (stall),
      .edge_count   (edge_count),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [7:0]  ivl;
      logic        lck;
      logic        mis;
      logic        stl;
      logic [15:0] ec;
      logic [7:0]  erc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_vec   = 0;
   int   n_err   = 0;
   int   pcnt    = 0;
   int   vld_cnt = 0;

   // edge-level reference state: 0 idle, 1 acquire, 2 locked
   int   m_state, m_match, m_ec, m_erc, m_ivl, last_pc;
   logic m_mis, m_stl;

   always @(posedge clk) pcnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_match = 0; m_ec = 0; m_erc = 0; m_ivl = 0;
      m_mis = 1'b0; m_stl = 1'b0; last_pc = pcnt;
      sb_q.delete();
   endtask

   always @(posedge clk) begin
      #1;
      if (edge_pulse === 1'b1) begin
         check("sb_avail", {31'd0, sb_q.size() > 0}, 32'd1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("interval_vld", {31'd0, interval_vld}, {31'd0, mon_e.vld});
            check("interval",     {24'd0, interval},     {24'd0, mon_e.ivl});
            check("locked",       {31'd0, locked},       {31'd0, mon_e.lck});
            check("mismatch",     {31'd0, mismatch},     {31'd0, mon_e.mis});
            check("stall",        {31'd0, stall},        {31'd0, mon_e.stl});
            check("edge_count",   {16'd0, edge_count},   {16'd0, mon_e.ec});
            check("err_count",    {24'd0, err_count},    {24'd0, mon_e.erc});
         end
         if (interval_vld === 1'b1) vld_cnt++;
      end else begin
         check("vld_without_edge", {31'd0, interval_vld}, 32'd0);
      end
   end

   // Flip toggle_in g cycles after the previous flip and push the expected response.
   task automatic gap_edge(input int g, input bit clr);
      int   gap;
      exp_t x;
      repeat (g) @(negedge clk);
      toggle_in = ~toggle_in;
      clear     = clr;
      gap       = pcnt - last_pc;
      last_pc   = pcnt;
      if (m_state != 0 && gap > TIMEOUT) begin
         m_state = 0; m_match = 0; m_stl = 1'b1;
      end
      x.vld = 1'b0;
      m_ec  = (m_ec + 1) & 32'hFFFF;
      case (m_state)
         0: begin
            m_state = 1; m_match = 0;
         end
         1: begin
            x.vld = 1'b1;
            m_ivl = (gap > 255) ? 255 : gap;
            if (m_ivl == EXP_HALF) begin
               m_match++;
               if (m_match == LOCK_CNT) begin m_state = 2; m_match = 0; end
            end else begin
               m_match = 0;
            end
         end
         default: begin
            x.vld = 1'b1;
            m_ivl = (gap > 255) ? 255 : gap;
            if (m_ivl != EXP_HALF) begin
               m_mis = 1'b1;
               if (m_erc < 255) m_erc++;
               m_state = 1; m_match = 0;
            end
         end
      endcase
      if (clr) begin
         m_mis = 1'b0; m_stl = 1'b0; m_ec = 0; m_erc = 0;
      end
      x.ivl = 8'(m_ivl);
      x.lck = (m_state == 2);
      x.mis = m_mis;
      x.stl = m_stl;
      x.ec  = STATS ? 16'(m_ec)  : 16'd0;
      x.erc = STATS ? 8'(m_erc)  : 8'd0;
      sb_q.push_back(x);
      if (clr) begin
         @(posedge clk);
         #2 clear = 1'b0;
      end
   endtask

   // Called straight after the last flip of a locked stream.
   task automatic check_stall_timing();
      @(posedge clk);
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      check("stall_early",     {31'd0, stall},  32'd0);
      check("locked_pre_tmo",  {31'd0, locked}, 32'd1);
      @(posedge clk);
      #1;
      check("stall_set",       {31'd0, stall},  32'd1);
      check("locked_drop_tmo", {31'd0, locked}, 32'd0);
      m_state = 0; m_match = 0; m_stl = 1'b1;
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      m_mis = 1'b0; m_stl = 1'b0; m_ec = 0; m_erc = 0;
      @(posedge clk);
      #1;
      check("clr_mismatch",   {31'd0, mismatch},   32'd0);
      check("clr_stall",      {31'd0, stall},      32'd0);
      check("clr_edge_count", {16'd0, edge_count}, 32'd0);
      check("clr_err_count",  {24'd0, err_count},  32'd0);
      check("clr_state_kept", {31'd0, locked},     32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_edge_pulse"}, {31'd0, edge_pulse},   32'd0);
      check({tag, "_interval"},   {24'd0, interval},     32'd0);
      check({tag, "_vld"},        {31'd0, interval_vld}, 32'd0);
      check({tag, "_locked"},     {31'd0, locked},       32'd0);
      check({tag, "_mismatch"},   {31'd0, mismatch},     32'd0);
      check({tag, "_stall"},      {31'd0, stall},        32'd0);
      check({tag, "_edge_count"}, {16'd0, edge_count},   32'd0);
      check({tag, "_err_count"},  {24'd0, err_count},    32'd0);
   endtask

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // 3-cycle stream: lock one cycle after the 5th edge
      gap_edge(2, 1'b0);
      repeat (5) gap_edge(3, 1'b0);

      // stretched half-period breaks lock; 4 good intervals relock
      gap_edge(5, 1'b0);
      repeat (4) gap_edge(3, 1'b0);

      // edge exactly at TIMEOUT is a measured interval, not a stall
      gap_edge(TIMEOUT, 1'b0);
      repeat (4) gap_edge(3, 1'b0);

      // hold toggle_in while locked
      check_stall_timing();
      pulse_clear();

      // relock after stall, reach edge_count 7, then clear on an edge
      gap_edge(2, 1'b0);
      repeat (6) gap_edge(3, 1'b0);
      gap_edge(3, 1'b1);
      repeat (2) @(posedge clk);
      #1 check("clr_edge_lock_kept", {31'd0, locked}, 32'd1);

      // reset while in ACQUIRE with cyc_cnt = 2
      gap_edge(3, 1'b0);
      gap_edge(5, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst_n     = 1'b0;
      toggle_in = 1'b0;
      #1 check_all_zero("arst");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_pc = pcnt;
      vld_cnt = 0;
      repeat (6) gap_edge(3, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("vld_pulses_after_rst", vld_cnt, 32'd5);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
